// File: rtl/hash_checker_pkg.sv
// Shared types and register-map constants for the hash result checker.
package hash_checker_pkg;

  localparam int ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_DIGEST0 = 5'd0;
  localparam logic [ADDR_W-1:0] ADDR_TARGET0 = 5'd8;
  localparam logic [ADDR_W-1:0] ADDR_STATUS  = 5'd16;
  localparam logic [ADDR_W-1:0] ADDR_CTRL    = 5'd17;
  localparam logic [ADDR_W-1:0] ADDR_COUNT   = 5'd18;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_FOUND    = 2;
  localparam int STAT_OVERFLOW = 3;

  localparam int CTRL_CLEAR  = 0;
  localparam int CTRL_IRQ_EN = 1;

endpackage

// File: rtl/hash_word_cmp.sv
// Combinational unsigned magnitude compare of one digest word against one target word.
module hash_word_cmp #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         lt_o,
  output logic         eq_o,
  output logic         gt_o
);

  assign lt_o = (a_i < b_i);
  assign eq_o = (a_i == b_i);
  assign gt_o = (a_i > b_i);

endmodule

// File: rtl/hash_result_checker.sv
// Captures SHA-256 digests, compares them MSW-first against a programmable target
// (found = digest <= target) and exposes results on a 32-bit slave bus.
module hash_result_checker
  import hash_checker_pkg::*;
#(
  parameter int DIGEST_W = 256,
  parameter int WORD_W   = 32,
  parameter int NWORDS   = DIGEST_W / WORD_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hash_valid,
  input  logic [DIGEST_W-1:0] hash_digest,
  output logic                hash_ready,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [ADDR_W-1:0]   address,
  input  logic [WORD_W-1:0]   writedata,
  output logic [WORD_W-1:0]   readdata,
  output logic                irq
);

  localparam int IDX_W = $clog2(NWORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_TARGET_END = ADDR_TARGET0 + ADDR_W'(NWORDS);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WORD_W-1:0]  digest_q [NWORDS];
  logic [WORD_W-1:0]  target_q [NWORDS];
  logic               found_q, found_d;
  logic               overflow_q, overflow_d;
  logic               irq_en_q, irq_en_d;
  logic [WORD_W-1:0]  count_q, count_d;
  logic [WORD_W-1:0]  readdata_q, readdata_d;

  logic               bus_wr, bus_rd, ctrl_wr, clear_cmd;
  logic               capture, drop;
  logic               cmp_lt, cmp_eq, cmp_gt;
  logic [WORD_W-1:0]  cur_digest, cur_target;
  logic [WORD_W-1:0]  status_word, rd_word;
  logic [NWORDS-1:0]  tgt_we;
  logic [WORD_W-1:0]  digest_words [NWORDS];

  assign bus_wr    = chipselect && write;
  assign bus_rd    = chipselect && read;
  assign ctrl_wr   = bus_wr && (address == ADDR_CTRL);
  assign clear_cmd = ctrl_wr && writedata[CTRL_CLEAR];
  assign capture   = hash_valid && (state_q == IDLE);
  assign drop      = hash_valid && (state_q != IDLE);

  assign hash_ready = (state_q == IDLE);
  assign irq        = (state_q == DONE) && irq_en_q;
  assign readdata   = readdata_q;

  // Target words are frozen while a compare walks through them.
  for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
    localparam logic [ADDR_W-1:0] TGT_ADDR = ADDR_TARGET0 + ADDR_W'(gi);
    assign tgt_we[gi]       = bus_wr && (address == TGT_ADDR) && (state_q != COMPARE);
    assign digest_words[gi] = hash_digest[DIGEST_W-1-gi*WORD_W -: WORD_W];
  end

  assign cur_digest = digest_q[idx_q];
  assign cur_target = target_q[idx_q];

  hash_word_cmp #(
    .W(WORD_W)
  ) u_cmp (
    .a_i  (cur_digest),
    .b_i  (cur_target),
    .lt_o (cmp_lt),
    .eq_o (cmp_eq),
    .gt_o (cmp_gt)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    found_d = found_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = COMPARE;
          idx_d   = '0;
          found_d = 1'b0;
        end
      end
      COMPARE: begin
        if (cmp_lt || (cmp_eq && idx_q == LAST_IDX)) begin
          found_d = 1'b1;
          state_d = DONE;
          count_d = count_q + 1'b1;
        end else if (cmp_gt) begin
          found_d = 1'b0;
          state_d = DONE;
          count_d = count_q + 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (clear_cmd) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A dropped digest in the same cycle as a clear still leaves overflow set.
  always_comb begin
    overflow_d = overflow_q;
    if (clear_cmd) overflow_d = 1'b0;
    if (drop)      overflow_d = 1'b1;
    irq_en_d = irq_en_q;
    if (ctrl_wr) irq_en_d = writedata[CTRL_IRQ_EN];
  end

  always_comb begin
    status_word                = '0;
    status_word[STAT_BUSY]     = (state_q == COMPARE);
    status_word[STAT_DONE]     = (state_q == DONE);
    status_word[STAT_FOUND]    = found_q;
    status_word[STAT_OVERFLOW] = overflow_q;
  end

  always_comb begin
    rd_word = '0;
    if (address < ADDR_TARGET0) begin
      rd_word = digest_q[address[IDX_W-1:0]];
    end else if (address < ADDR_TARGET_END) begin
      rd_word = target_q[address[IDX_W-1:0]];
    end else if (address == ADDR_STATUS) begin
      rd_word = status_word;
    end else if (address == ADDR_COUNT) begin
      rd_word = count_q;
    end
    readdata_d = bus_rd ? rd_word : readdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      found_q    <= 1'b0;
      overflow_q <= 1'b0;
      irq_en_q   <= 1'b0;
      count_q    <= '0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      found_q    <= found_d;
      overflow_q <= overflow_d;
      irq_en_q   <= irq_en_d;
      count_q    <= count_d;
      readdata_q <= readdata_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NWORDS; i++) begin
        digest_q[i] <= '0;
        target_q[i] <= '1;
      end
    end else begin
      for (int i = 0; i < NWORDS; i++) begin
        if (capture)   digest_q[i] <= digest_words[i];
        if (tgt_we[i]) target_q[i] <= writedata;
      end
    end
  end

endmodule

// File: tb/tb_hash_result_checker.sv
// Directed bench for hash_result_checker: vector table plus overflow and reset sequences.
module tb_hash_result_checker;
  import hash_checker_pkg::*;

  localparam logic [255:0] D =
    256'h80cab0c8_ef5701ae_d57f628f_d04511fd_4f2040ba_721acb80_c48650a4_677f47be;
  localparam logic [255:0] ALL_F = {8{32'hFFFFFFFF}};

  typedef struct {
    logic [255:0] tgt;
    logic [255:0] dig;
    logic         found;
    int           k;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         hash_valid = 1'b0;
  logic [255:0] hash_digest = '0;
  logic         hash_ready;
  logic         chipselect = 1'b0;
  logic         read = 1'b0;
  logic         write = 1'b0;
  logic [4:0]   address = '0;
  logic [31:0]  writedata = '0;
  logic [31:0]  readdata;
  logic         irq;

  int checks = 0;
  int errors = 0;

  hash_result_checker dut (
    .clk         (clk),
    .reset       (reset),
    .hash_valid  (hash_valid),
    .hash_digest (hash_digest),
    .hash_ready  (hash_ready),
    .chipselect  (chipselect),
    .read        (read),
    .write       (write),
    .address     (address),
    .writedata   (writedata),
    .readdata    (readdata),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic write_target(input logic [255:0] t);
    for (int w = 0; w < 8; w++)
      bus_write(ADDR_TARGET0 + 5'(w), t[255-32*w -: 32]);
  endtask

  task automatic pulse_hash(input logic [255:0] d);
    hash_digest = d; hash_valid = 1'b1;
    @(posedge clk); #1;
    hash_valid = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!irq && k < 20);
  endtask

  vec_t        vecs [8];
  logic [31:0] r;
  int          k;

  initial begin
    vecs[0] = '{tgt: ALL_F,                           dig: D,     found: 1'b1, k: 1};
    vecs[1] = '{tgt: {32'h0, {7{32'hFFFFFFFF}}},      dig: D,     found: 1'b0, k: 1};
    vecs[2] = '{tgt: D,                               dig: D,     found: 1'b1, k: 8};
    vecs[3] = '{tgt: D - 256'd1,                      dig: D,     found: 1'b0, k: 8};
    vecs[4] = '{tgt: D + (256'd1 << 128),             dig: D,     found: 1'b1, k: 4};
    vecs[5] = '{tgt: D - (256'd1 << 64),              dig: D,     found: 1'b0, k: 6};
    vecs[6] = '{tgt: '0,                              dig: '0,    found: 1'b1, k: 8};
    vecs[7] = '{tgt: ALL_F,                           dig: ALL_F, found: 1'b1, k: 8};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst hash_ready", 32'(hash_ready), 32'h1);
    check("rst irq", 32'(irq), 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    bus_read(ADDR_TARGET0, r); check("rst target0", r, 32'hFFFFFFFF);
    bus_read(ADDR_STATUS, r);  check("rst status", r, 32'h0);
    bus_read(ADDR_COUNT, r);   check("rst count", r, 32'h0);
    bus_read(ADDR_DIGEST0, r); check("rst digest0", r, 32'h0);

    bus_write(ADDR_CTRL, 32'h2);

    for (int i = 0; i < 8; i++) begin
      write_target(vecs[i].tgt);
      pulse_hash(vecs[i].dig);
      check($sformatf("v%0d ready low", i), 32'(hash_ready), 32'h0);
      wait_done(k);
      check($sformatf("v%0d latency", i), 32'(k), 32'(vecs[i].k));
      bus_read(ADDR_STATUS, r);
      check($sformatf("v%0d status", i), r, {29'b0, vecs[i].found, 2'b10});
      bus_read(ADDR_COUNT, r);
      check($sformatf("v%0d count", i), r, 32'(i + 1));
      bus_read(ADDR_DIGEST0, r);
      check($sformatf("v%0d digest0", i), r, vecs[i].dig[255:224]);
      bus_read(ADDR_DIGEST0 + 5'd7, r);
      check($sformatf("v%0d digest7", i), r, vecs[i].dig[31:0]);
      bus_write(ADDR_CTRL, 32'h3);
      check($sformatf("v%0d ready after clear", i), 32'(hash_ready), 32'h1);
      check($sformatf("v%0d irq after clear", i), 32'(irq), 32'h0);
      bus_read(ADDR_STATUS, r);
      check($sformatf("v%0d status idle", i), r, {29'b0, vecs[i].found, 2'b00});
    end

    // Overflow, frozen target, clear during COMPARE, clear+valid in DONE
    write_target(D - 256'd1);
    pulse_hash(D);
    hash_digest = '0; hash_valid = 1'b1;
    @(posedge clk); #1;
    hash_valid = 1'b0;
    bus_read(ADDR_STATUS, r);        check("ovf status busy+ovf", r, 32'h9);
    bus_write(ADDR_TARGET0, 32'h0);
    bus_write(ADDR_CTRL, 32'h3);
    check("ovf still busy", 32'(hash_ready), 32'h0);
    bus_read(ADDR_STATUS, r);        check("ovf cleared in compare", r, 32'h1);
    wait_done(k);                    check("ovf remaining latency", 32'(k), 32'd3);
    chipselect = 1'b1; write = 1'b1; address = ADDR_CTRL; writedata = 32'h3;
    hash_digest = '0; hash_valid = 1'b1;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0; hash_valid = 1'b0;
    check("ovf ready after clear", 32'(hash_ready), 32'h1);
    bus_read(ADDR_STATUS, r);        check("ovf status after clear", r, 32'h8);
    bus_read(ADDR_DIGEST0, r);       check("ovf digest kept", r, 32'h80cab0c8);
    bus_read(ADDR_TARGET0, r);       check("ovf target write ignored", r, 32'h80cab0c8);
    bus_read(ADDR_COUNT, r);         check("ovf count", r, 32'd9);
    bus_write(ADDR_CTRL, 32'h3);
    bus_read(ADDR_STATUS, r);        check("ovf status final", r, 32'h0);

    // Reset mid-compare
    write_target(D);
    pulse_hash(D);
    repeat (3) begin @(posedge clk); #1; end
    check("mid busy before reset", 32'(hash_ready), 32'h0);
    reset = 1'b0;
    #1;
    check("mid ready in reset", 32'(hash_ready), 32'h1);
    check("mid irq in reset", 32'(irq), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    bus_read(ADDR_STATUS, r);        check("mid status", r, 32'h0);
    bus_read(ADDR_TARGET0, r);       check("mid target0", r, 32'hFFFFFFFF);
    bus_read(ADDR_COUNT, r);         check("mid count", r, 32'h0);
    bus_read(ADDR_CTRL, r);          check("ctrl reads zero", r, 32'h0);

    // irq gated by irq_en, then enabled without clearing
    pulse_hash(D);
    repeat (2) begin @(posedge clk); #1; end
    bus_read(ADDR_STATUS, r);        check("noirq status", r, 32'h6);
    check("noirq irq low", 32'(irq), 32'h0);
    bus_write(ADDR_CTRL, 32'h2);
    check("irq_en irq high", 32'(irq), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hash_result_checker.md
Name: hash_result_checker

Overview:
Downstream of the SHA-256 accelerator top. Captures each finished 256-bit digest and compares it word-serially, MSW first, against a software-programmed 256-bit difficulty target (found = digest <= target). Exposes digest, target, status and a hash counter on the same 32-bit chipselect/read/write slave bus used by the accelerator. Raises an optional interrupt when a result is ready.

Parameters:
DIGEST_W, 256, digest and target width in bits
WORD_W, 32, bus word width
NWORDS, 8, DIGEST_W/WORD_W, number of words compared

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
hash_valid  in  1  digest valid pulse from the accelerator
hash_digest  in  256  digest; word0 = [255:224]
hash_ready  out  1  high only in IDLE; a digest is accepted on hash_valid && hash_ready
chipselect  in  1  slave select
read  in  1  read strobe
write  in  1  write strobe
address  in  5  word address
writedata  in  32  write data
readdata  out  32  registered read data, 1-cycle latency
irq  out  1  level interrupt = done && irq_en

Behaviour:
- Register map:
  - 0-7 digest words, RO; word0 = MSW.
  - 8-15 target words, RW; 8 = MSW.
  - 16 status, RO: {28'b0, overflow, found, done, busy}.
  - 17 control, WO: bit0 clear (self-clearing), bit1 irq_en (held).
  - 18 hash_count, RO.
  - Other addresses read 0; writes to them are ignored.
- Reset (async, reset=0):
  - state=IDLE; digest regs=0; target regs=all 32'hFFFFFFFF.
  - done, found, overflow, irq_en, hash_count, readdata, irq = 0; hash_ready=1.
- FSM IDLE -> COMPARE -> DONE -> IDLE:
  - IDLE: on hash_valid, latch digest and set idx=0; go to COMPARE (busy=1).
  - COMPARE: each cycle compare digest[idx] vs target[idx], unsigned.
    - d < t: found=1, go to DONE.
    - d > t: found=0, go to DONE.
    - equal: idx+1. If idx==NWORDS-1 and equal, found=1 and go to DONE.
  - Entry to DONE sets done=1 and increments hash_count (32-bit, wraps at FFFFFFFF to 0).
  - Latency: done visible k cycles after the capture edge, where k = decisive word index + 1, k = 1..8.
  - DONE: holds digest and found until a control write with bit0=1, then IDLE. done=0; found stays valid until the next capture.
- Boundary conditions:
  - hash_valid while hash_ready=0 (COMPARE/DONE): digest dropped, overflow set (sticky, cleared only by the clear command).
  - Clear written in IDLE or COMPARE: only clears overflow, no state change.
  - Clear and hash_valid in the same cycle in DONE: clear wins, digest not accepted, overflow set.
  - Target writes during COMPARE are ignored; writes in IDLE/DONE take effect next cycle.
  - Reads are allowed in any state. Readdata updates only when chipselect && read; otherwise it holds.
  - Reset asserted mid-COMPARE: immediate return to the reset values above; the partial compare is discarded.

Decomposition:
- Package hash_checker_pkg:
  - state enum {IDLE, COMPARE, DONE}.
  - Address constants ADDR_DIGEST0=0, ADDR_TARGET0=8, ADDR_STATUS=16, ADDR_CTRL=17, ADDR_COUNT=18.
  - Status bit indices.
- One sub-module, hash_word_cmp: combinational 32-bit unsigned compare returning {lt, eq, gt}.
- The FSM, register file and bus decode stay in the top.

Test Plan:
- Reset -> hash_ready=1, irq=0; read addr 8 returns FFFFFFFF; addr 16 returns 0; addr 18 returns 0.
- Default target, pulse hash_valid with digest 80cab0c8ef5701aed57f628fd04511fd4f2040ba721acb80c48650a4677f47be, irq_en=1 -> done 1 cycle after capture, status=0x6, irq=1, addr 0 reads 80cab0c8, count=1.
- Target word0=0x00000000 (rest FF), same digest -> done after 1 cycle, found=0, status=0x2.
- Target = same digest exactly -> done after 8 cycles, found=1. Then target word7=0x677f47bd, clear, resend -> done after 8 cycles, found=0.
- hash_valid during COMPARE, and again together with a clear in DONE -> both dropped, overflow=1. After the clear, status=0, hash_ready=1, count unchanged by the drops.
- Assert reset on cycle 3 of an 8-word compare -> next edge state IDLE, busy=0, done=0, target reads back FFFFFFFF.
